id_ex_alu_ctrl: RTL and testbench

ID/EX pipeline stage of the MIPS-Lite CPU.
- Registers decoded-instruction state and produces, one cycle later, the per-slice ALU controls (sel, binv, cin) and the operands that drive the 32-bit chain of 1-bit ALU slices.
- Implements stall (hold) and flush (bubble) for hazard handling.
- Sits between the register-file read in ID and the ripple ALU in EX.

---
 rtl/id_ex_alu_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_alu_ctrl
// Description : MIPS-Lite ID/EX pipeline register. Decodes the ID instruction
//               into per-slice ALU controls and operands one cycle later.
//               Handles stall (hold) and flush (bubble).
//               Optional illegal-encoding flag: ID_EX_ILLEGAL_DET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_alu_ctrl #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [1:0]    ex_alu_sel,
  output logic          ex_binv,
  output logic          ex_cin,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_wr_en,
  output logic [RW-1:0] ex_wr_addr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_branch,
  output logic          ex_illegal
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_slti  = 6'h0A;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  localparam logic [1:0] c_sel_and = 2'b00;
  localparam logic [1:0] c_sel_or  = 2'b01;
  localparam logic [1:0] c_sel_add = 2'b10;
  localparam logic [1:0] c_sel_slt = 2'b11;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [RW-1:0] rt_addr;
  logic [RW-1:0] rd_addr;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic          unused_rs_field;

  assign op       = id_instr[31:26];
  assign funct    = id_instr[5:0];
  assign imm      = id_instr[15:0];
  assign rt_addr  = id_instr[20:16];
  assign rd_addr  = id_instr[15:11];
  assign imm_sext = {{(DW-16){imm[15]}}, imm};
  assign imm_zext = {{(DW-16){1'b0}}, imm};
  // rs arrives pre-read as id_rs_data; its address field is not needed here.
  assign unused_rs_field = &{1'b0, id_instr[25:21]};

  logic [1:0]    dec_sel;
  logic          dec_binv;
  logic [DW-1:0] dec_b;
  logic [DW-1:0] dec_store;
  logic          dec_wr;
  logic [RW-1:0] dec_wr_addr;
  logic          dec_mem_rd;
  logic          dec_mem_wr;
  logic          dec_branch;
  logic          dec_illegal;

  always_comb begin
    dec_sel     = c_sel_and;
    dec_binv    = 1'b0;
    dec_b       = id_rt_data;
    dec_store   = '0;
    dec_wr      = 1'b0;
    dec_wr_addr = '0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      c_op_rtype: begin
        dec_wr      = 1'b1;
        dec_wr_addr = rd_addr;
        case (funct)
          c_fn_add: dec_sel = c_sel_add;
          c_fn_sub: begin
            dec_sel  = c_sel_add;
            dec_binv = 1'b1;
          end
          c_fn_and: dec_sel = c_sel_and;
          c_fn_or:  dec_sel = c_sel_or;
          c_fn_slt: begin
            dec_sel  = c_sel_slt;
            dec_binv = 1'b1;
          end
          default: begin
            dec_wr      = 1'b0;
            dec_wr_addr = '0;
`ifdef ID_EX_ILLEGAL_DET_EN
            // The all-zero word is the architectural nop, not an illegal encoding.
            dec_illegal = (id_instr != 32'h0);
`endif
          end
        endcase
      end
      c_op_addi: begin
        dec_sel     = c_sel_add;
        dec_b       = imm_sext;
        dec_wr      = 1'b1;
        dec_wr_addr = rt_addr;
      end
      c_op_slti: begin
        dec_sel     = c_sel_slt;
        dec_binv    = 1'b1;
        dec_b       = imm_sext;
        dec_wr      = 1'b1;
        dec_wr_addr = rt_addr;
      end
      c_op_andi: begin
        dec_sel     = c_sel_and;
        dec_b       = imm_zext;
        dec_wr      = 1'b1;
        dec_wr_addr = rt_addr;
      end
      c_op_ori: begin
        dec_sel     = c_sel_or;
        dec_b       = imm_zext;
        dec_wr      = 1'b1;
        dec_wr_addr = rt_addr;
      end
      c_op_lw: begin
        dec_sel     = c_sel_add;
        dec_b       = imm_sext;
        dec_mem_rd  = 1'b1;
        dec_wr      = 1'b1;
        dec_wr_addr = rt_addr;
      end
      c_op_sw: begin
        dec_sel    = c_sel_add;
        dec_b      = imm_sext;
        dec_mem_wr = 1'b1;
        dec_store  = id_rt_data;
      end
      c_op_beq: begin
        dec_sel    = c_sel_add;
        dec_binv   = 1'b1;
        dec_branch = 1'b1;
      end
      default: begin
`ifdef ID_EX_ILLEGAL_DET_EN
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  logic          valid_d,   valid_q;
  logic [1:0]    sel_d,     sel_q;
  logic          binv_d,    binv_q;
  logic [DW-1:0] a_d,       a_q;
  logic [DW-1:0] b_d,       b_q;
  logic [DW-1:0] store_d,   store_q;
  logic          wr_en_d,   wr_en_q;
  logic [RW-1:0] wr_addr_d, wr_addr_q;
  logic          mem_rd_d,  mem_rd_q;
  logic          mem_wr_d,  mem_wr_q;
  logic          branch_d,  branch_q;
  logic          illegal_d, illegal_q;

  always_comb begin
    valid_d   = valid_q;
    sel_d     = sel_q;
    binv_d    = binv_q;
    a_d       = a_q;
    b_d       = b_q;
    store_d   = store_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    // A bubble is the all-zero state, identical to the reset state.
    if (flush || (!stall && !id_valid)) begin
      valid_d   = 1'b0;
      sel_d     = c_sel_and;
      binv_d    = 1'b0;
      a_d       = '0;
      b_d       = '0;
      store_d   = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      branch_d  = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = 1'b1;
      sel_d     = dec_sel;
      binv_d    = dec_binv;
      a_d       = id_rs_data;
      b_d       = dec_b;
      store_d   = dec_store;
      wr_en_d   = dec_wr && (dec_wr_addr != '0);
      wr_addr_d = dec_wr_addr;
      mem_rd_d  = dec_mem_rd;
      mem_wr_d  = dec_mem_wr;
      branch_d  = dec_branch;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      sel_q     <= c_sel_and;
      binv_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      store_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      binv_q    <= binv_d;
      a_q       <= a_d;
      b_q       <= b_d;
      store_q   <= store_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_sel    = sel_q;
  assign ex_binv       = binv_q;
  assign ex_cin        = binv_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_store_data = store_q;
  assign ex_wr_en      = wr_en_q;
  assign ex_wr_addr    = wr_addr_q;
  assign ex_mem_rd     = mem_rd_q;
  assign ex_mem_wr     = mem_wr_q;
  assign ex_branch     = branch_q;
  assign ex_illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_alu_ctrl
// Description : Directed self-checking bench for id_ex_alu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_alu_sel;
  logic        ex_binv;
  logic        ex_cin;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_addr;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_branch;
  logic        ex_illegal;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ID_EX_ILLEGAL_DET_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  id_ex_alu_ctrl #(.DW(32), .RW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_alu_sel    (ex_alu_sel),
    .ex_binv       (ex_binv),
    .ex_cin        (ex_cin),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_store_data (ex_store_data),
    .ex_wr_en      (ex_wr_en),
    .ex_wr_addr    (ex_wr_addr),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_branch     (ex_branch),
    .ex_illegal    (ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Control group: valid, sel, binv (cin must track it), wr_en, wr_addr, mem_rd, mem_wr, branch, illegal
  task automatic chk_ctl(input string tag, input logic v, input logic [1:0] sel, input logic binv,
                         input logic we, input logic [4:0] wa, input logic mr, input logic mw,
                         input logic br, input logic il);
    chk({tag, ".valid"},   {31'h0, ex_valid},   {31'h0, v});
    chk({tag, ".sel"},     {30'h0, ex_alu_sel}, {30'h0, sel});
    chk({tag, ".binv"},    {31'h0, ex_binv},    {31'h0, binv});
    chk({tag, ".cin"},     {31'h0, ex_cin},     {31'h0, binv});
    chk({tag, ".wr_en"},   {31'h0, ex_wr_en},   {31'h0, we});
    chk({tag, ".wr_addr"}, {27'h0, ex_wr_addr}, {27'h0, wa});
    chk({tag, ".mem_rd"},  {31'h0, ex_mem_rd},  {31'h0, mr});
    chk({tag, ".mem_wr"},  {31'h0, ex_mem_wr},  {31'h0, mw});
    chk({tag, ".branch"},  {31'h0, ex_branch},  {31'h0, br});
    chk({tag, ".illegal"}, {31'h0, ex_illegal}, {31'h0, il});
  endtask

  task automatic chk_dat(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd);
    chk({tag, ".a"},     ex_a,          a);
    chk({tag, ".b"},     ex_b,          b);
    chk({tag, ".store"}, ex_store_data, sd);
  endtask

  // Drive one ID-stage word, then sample 1 ns after the loading edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt, input logic st, input logic fl);
    id_valid   = v;
    id_instr   = instr;
    id_rs_data = rs;
    id_rt_data = rt;
    stall      = st;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    stall = 1'b0; flush = 1'b0;
    #2;
    chk_ctl("reset", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);
    chk_dat("reset", 32'h0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // sub $3,$1,$2
    step(1, 32'h00221822, 32'd7, 32'd5, 0, 0);
    chk_ctl("sub", 1, 2'b10, 1, 1, 5'd3, 0, 0, 0, 0);
    chk_dat("sub", 32'd7, 32'd5, 32'h0);

    // addi $4,$0,-1
    step(1, 32'h2004FFFF, 32'h10, 32'h55, 0, 0);
    chk_ctl("addi", 1, 2'b10, 0, 1, 5'd4, 0, 0, 0, 0);
    chk_dat("addi", 32'h10, 32'hFFFFFFFF, 32'h0);

    // ori $4,$0,0xFFFF
    step(1, 32'h3404FFFF, 32'h0, 32'h55, 0, 0);
    chk_ctl("ori", 1, 2'b01, 0, 1, 5'd4, 0, 0, 0, 0);
    chk_dat("ori", 32'h0, 32'h0000FFFF, 32'h0);

    // slti $5,$0,-32768
    step(1, 32'h28058000, 32'h3, 32'h1, 0, 0);
    chk_ctl("slti", 1, 2'b11, 1, 1, 5'd5, 0, 0, 0, 0);
    chk_dat("slti", 32'h3, 32'hFFFF8000, 32'h0);

    // andi $6,$0,0x8000 (zero-extended)
    step(1, 32'h30068000, 32'hF0F0F0F0, 32'h1, 0, 0);
    chk_ctl("andi", 1, 2'b00, 0, 1, 5'd6, 0, 0, 0, 0);
    chk_dat("andi", 32'hF0F0F0F0, 32'h00008000, 32'h0);

    // R-type and / or / slt / add, rd=3
    step(1, 32'h00221824, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0);
    chk_ctl("and", 1, 2'b00, 0, 1, 5'd3, 0, 0, 0, 0);
    chk_dat("and", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0);
    step(1, 32'h00221825, 32'h1, 32'h2, 0, 0);
    chk_ctl("or", 1, 2'b01, 0, 1, 5'd3, 0, 0, 0, 0);
    step(1, 32'h0022182A, 32'h80000000, 32'h1, 0, 0);
    chk_ctl("slt", 1, 2'b11, 1, 1, 5'd3, 0, 0, 0, 0);
    chk_dat("slt", 32'h80000000, 32'h1, 32'h0);
    step(1, 32'h00221820, 32'hFFFFFFFF, 32'h1, 0, 0);
    chk_ctl("add", 1, 2'b10, 0, 1, 5'd3, 0, 0, 0, 0);

    // lw $3,8($1), then stall 3 cycles with changing inputs
    step(1, 32'h8C230008, 32'h100, 32'h77, 0, 0);
    chk_ctl("lw", 1, 2'b10, 0, 1, 5'd3, 1, 0, 0, 0);
    chk_dat("lw", 32'h100, 32'h8, 32'h0);
    step(1, 32'h00221822, 32'h1, 32'h2, 1, 0);
    chk_ctl("stall1", 1, 2'b10, 0, 1, 5'd3, 1, 0, 0, 0);
    step(0, 32'hAC220004, 32'h3, 32'h4, 1, 0);
    chk_dat("stall2", 32'h100, 32'h8, 32'h0);
    step(1, 32'h3404FFFF, 32'h5, 32'h6, 1, 0);
    chk_ctl("stall3", 1, 2'b10, 0, 1, 5'd3, 1, 0, 0, 0);
    chk_dat("stall3", 32'h100, 32'h8, 32'h0);

    // stall + flush: flush wins
    step(1, 32'h8C230008, 32'h100, 32'h77, 1, 1);
    chk_ctl("flush", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);
    chk_dat("flush", 32'h0, 32'h0, 32'h0);

    // add $0,$1,$2 -> no write
    step(1, 32'h00220020, 32'h9, 32'h8, 0, 0);
    chk_ctl("add0", 1, 2'b10, 0, 0, 5'd0, 0, 0, 0, 0);

    // sw $2,4($1)
    step(1, 32'hAC220004, 32'h200, 32'hDEAD, 0, 0);
    chk_ctl("sw", 1, 2'b10, 0, 0, 5'd0, 0, 1, 0, 0);
    chk_dat("sw", 32'h200, 32'h4, 32'hDEAD);

    // beq $1,$2,3
    step(1, 32'h10220003, 32'h12, 32'h34, 0, 0);
    chk_ctl("beq", 1, 2'b10, 1, 0, 5'd0, 0, 0, 1, 0);
    chk_dat("beq", 32'h12, 32'h34, 32'h0);

    // id_valid=0 loads a bubble
    step(0, 32'h00221820, 32'h1, 32'h2, 0, 0);
    chk_ctl("novalid", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);
    chk_dat("novalid", 32'h0, 32'h0, 32'h0);

    // architectural nop
    step(1, 32'h00000000, 32'h0, 32'h0, 0, 0);
    chk_ctl("nop", 1, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);

    // unsupported opcode 0x3F, then held across a stall, then flushed
    step(1, 32'hFC000000, 32'h1, 32'h2, 0, 0);
    chk_ctl("illop", 1, 2'b00, 0, 0, 5'd0, 0, 0, 0, EXP_ILL);
    step(1, 32'h00221820, 32'h1, 32'h2, 1, 0);
    chk_ctl("illstall", 1, 2'b00, 0, 0, 5'd0, 0, 0, 0, EXP_ILL);
    step(1, 32'h00221820, 32'h1, 32'h2, 0, 1);
    chk_ctl("illflush", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);

    // unsupported R-type funct
    step(1, 32'h0022183F, 32'h1, 32'h2, 0, 0);
    chk_ctl("illfn", 1, 2'b00, 0, 0, 5'd0, 0, 0, 0, EXP_ILL);

    // async reset mid-cycle after loading sub (binv=1), checked before the next edge
    step(1, 32'h00221822, 32'h7, 32'h5, 0, 0);
    chk_ctl("pre_rst", 1, 2'b10, 1, 1, 5'd3, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_ctl("async_rst", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);
    chk_dat("async_rst", 32'h0, 32'h0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk_ctl("rst_hold", 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
